// File: rtl/mash111_ncn_pkg.sv
// -----------------------------------------------------------------------------
// mash111_ncn_pkg
// Shared constants and types for the MASH 1-1-1 modulator core.
//   P_WIDTH_DEF : default accumulator / fractional-word width
//   NCN_W       : width of the noise-cancellation network output
//   NCN_MIN/MAX : range the NCN output is guaranteed to stay within
//   ncn_t       : signed NCN sample type
//   dly_t       : carry delay line used by the NCN
// -----------------------------------------------------------------------------
package mash111_ncn_pkg;

    localparam int P_WIDTH_DEF = 16;
    localparam int NCN_W       = 4;
    localparam int NCN_MIN     = -3;
    localparam int NCN_MAX     = 4;

    typedef logic signed [NCN_W-1:0] ncn_t;

    // Past carries needed by the second- and third-order difference terms.
    typedef struct packed {
        logic c2_d;
        logic c3_d;
        logic c3_dd;
    } dly_t;

    // Zero-extends a single carry bit into the signed NCN domain.
    function automatic ncn_t carry_to_ncn(input logic c);
        return {{(NCN_W-1){1'b0}}, c};
    endfunction

endpackage

// File: rtl/mash_acc_stage.sv
// -----------------------------------------------------------------------------
// mash_acc_stage
// One first-order accumulator of the MASH cascade.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_en           : advance the accumulator at this edge
//   i_clr          : synchronous clear (priority over i_en)
//   i_addend       : value added this cycle
//   o_sum          : combinational wrapped sum, feeds the next stage
//   o_carry        : registered overflow of the last enabled update
// -----------------------------------------------------------------------------
module mash_acc_stage
    import mash111_ncn_pkg::*;
#(
    parameter int P_WIDTH = P_WIDTH_DEF
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_en,
    input  logic               i_clr,
    input  logic [P_WIDTH-1:0] i_addend,
    output logic [P_WIDTH-1:0] o_sum,
    output logic               o_carry
);

    logic [P_WIDTH-1:0] acc;
    logic [P_WIDTH:0]   sum_ext;

    assign sum_ext = {1'b0, acc} + {1'b0, i_addend};
    assign o_sum   = sum_ext[P_WIDTH-1:0];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, which the cascade and delay line rely on.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            acc     <= '0;
            o_carry <= 1'b0;
        end else if (i_clr) begin
            acc     <= '0;
            o_carry <= 1'b0;
        end else if (i_en) begin
            acc     <= o_sum;
            o_carry <= sum_ext[P_WIDTH];
        end
    end

endmodule

// File: rtl/mash111_ncn.sv
// -----------------------------------------------------------------------------
// mash111_ncn
// Third-order MASH 1-1-1 delta-sigma core with its noise-cancellation network.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_frac_vld     : load strobe for i_frac_word (shadow load, no restart)
//   i_frac_word    : unsigned fractional word x; mean output = x / 2^P_WIDTH
//   i_en           : advance the modulator at this edge
//   i_clr          : synchronous clear of modulator state (frac_reg kept)
//   o_network      : NCN output, two's complement, range -3..+4
//   o_vld          : o_network holds a sample from an enabled cycle
// -----------------------------------------------------------------------------
module mash111_ncn
    import mash111_ncn_pkg::*;
#(
    parameter int P_WIDTH = P_WIDTH_DEF
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_frac_vld,
    input  logic [P_WIDTH-1:0] i_frac_word,
    input  logic               i_en,
    input  logic               i_clr,
    output logic [NCN_W-1:0]   o_network,
    output logic               o_vld
);

    logic [P_WIDTH-1:0] frac_reg;
    logic [P_WIDTH-1:0] chain [4];   // chain[0] = x, chain[k+1] = sum of stage k
    logic [2:0]         carry;       // carry[k] = c(k+1)
    dly_t               dly;
    logic               stepped;     // preceding edge was an enabled cycle
    ncn_t               ncn_next;

    // Shadow register: a new word is picked up by the next enabled cycle
    // without disturbing accumulator state; i_clr does not touch it.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            frac_reg <= '0;
        end else if (i_frac_vld) begin
            frac_reg <= i_frac_word;
        end
    end

    assign chain[0] = frac_reg;

    for (genvar k = 0; k < 3; k++) begin : g_stage
        mash_acc_stage #(
            .P_WIDTH (P_WIDTH)
        ) u_stage (
            .i_clk    (i_clk),
            .i_rst_n  (i_rst_n),
            .i_en     (i_en),
            .i_clr    (i_clr),
            .i_addend (chain[k]),
            .o_sum    (chain[k+1]),
            .o_carry  (carry[k])
        );
    end

    // y = c1 + (1 - z^-1) c2 + (1 - z^-1)^2 c3. Mod-16 arithmetic is exact
    // because the true result never leaves -3..+4.
    assign ncn_next = carry_to_ncn(carry[0])
                    + carry_to_ncn(carry[1]) - carry_to_ncn(dly.c2_d)
                    + carry_to_ncn(carry[2])
                    - carry_to_ncn(dly.c3_d) - carry_to_ncn(dly.c3_d)
                    + carry_to_ncn(dly.c3_dd);

    // Delay line advances with the accumulators; the NCN result is
    // registered one edge after the carries it uses were produced.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            dly       <= '0;
            o_network <= '0;
            o_vld     <= 1'b0;
            stepped   <= 1'b0;
        end else if (i_clr) begin
            dly       <= '0;
            o_network <= '0;
            o_vld     <= 1'b0;
            stepped   <= 1'b0;
        end else begin
            if (i_en) begin
                dly.c2_d  <= carry[1];
                dly.c3_d  <= carry[2];
                dly.c3_dd <= dly.c3_d;
            end
            if (stepped) begin
                o_network <= ncn_next;
            end
            o_vld   <= stepped;
            stepped <= i_en;
        end
    end

endmodule
